// File: rtl/slice_alu_seq.sv
// Multi-cycle ALU that works on SLICE_W-bit slices, least significant first.
// The carry or borrow passes between slices through a register.
module slice_alu_seq #(
    parameter int SLICE_W = 16,
    parameter int NSLICE  = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         START,
    input  logic [2:0]                   OP,
    input  logic [$clog2(NSLICE)-1:0]    LEN,
    input  logic [SLICE_W*NSLICE-1:0]    A,
    input  logic [SLICE_W*NSLICE-1:0]    B,
    input  logic                         XIN,
    input  logic                         ZIN,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [SLICE_W*NSLICE-1:0]    RESULT,
    output logic [4:0]                   CCR
);

    localparam int OPW = SLICE_W * NSLICE;
    localparam int LW  = $clog2(NSLICE);
    localparam int M   = SLICE_W - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_EOR  = 3'd4;
    localparam logic [2:0] OP_ADDX = 3'd5;
    localparam logic [2:0] OP_SUBX = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    logic [0:0]     state;
    logic [2:0]     op_r;
    logic [LW-1:0]  len_r;
    logic [LW-1:0]  idx;
    logic [OPW-1:0] a_r;
    logic [OPW-1:0] b_r;
    logic [OPW-1:0] work;
    logic           xin_r;
    logic           zin_r;
    logic           cy;
    logic           zacc;
    logic           done_r;
    logic [OPW-1:0] result_r;
    logic [4:0]     ccr_r;

    logic [SLICE_W-1:0] sa;
    logic [SLICE_W-1:0] sb;
    logic [SLICE_W-1:0] d;
    logic [SLICE_W:0]   ext;
    logic [OPW-1:0]     work_nxt;
    logic               z_nxt;
    logic               v_s;
    logic               c_s;
    logic               is_sub;
    logic               is_arith;
    logic               x_ops;
    logic               last;
    logic [4:0]         ccr_nxt;

    always_comb begin
        sa       = a_r[int'(idx)*SLICE_W +: SLICE_W];
        sb       = b_r[int'(idx)*SLICE_W +: SLICE_W];
        is_sub   = (op_r == OP_SUB) || (op_r == OP_SUBX) || (op_r == OP_CMP);
        is_arith = is_sub || (op_r == OP_ADD) || (op_r == OP_ADDX);
        x_ops    = (op_r == OP_ADDX) || (op_r == OP_SUBX);
        ext      = '0;
        case (op_r)
            OP_ADD, OP_ADDX:
                ext = {1'b0, sa} + {1'b0, sb} + {{SLICE_W{1'b0}}, cy};
            OP_SUB, OP_SUBX, OP_CMP:
                ext = {1'b0, sa} - {1'b0, sb} - {{SLICE_W{1'b0}}, cy};
            OP_AND:  ext = {1'b0, sa & sb};
            OP_OR:   ext = {1'b0, sa | sb};
            OP_EOR:  ext = {1'b0, sa ^ sb};
            default: ext = '0;
        endcase
        d        = ext[SLICE_W-1:0];
        work_nxt = work;
        work_nxt[int'(idx)*SLICE_W +: SLICE_W] = d;
        z_nxt    = zacc & (d == '0);
        // Overflow only matters on the final slice, where d holds the sign bit
        if (is_sub)
            v_s = (sa[M] != sb[M]) && (d[M] != sa[M]);
        else
            v_s = (sa[M] == sb[M]) && (d[M] != sa[M]);
        c_s     = is_arith & ext[SLICE_W];
        ccr_nxt = {
            (is_arith && (op_r != OP_CMP)) ? c_s : xin_r,
            d[M],
            x_ops ? (zin_r & z_nxt) : z_nxt,
            is_arith & v_s,
            c_s
        };
        last = (idx == len_r);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            op_r     <= '0;
            len_r    <= '0;
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            work     <= '0;
            xin_r    <= 1'b0;
            zin_r    <= 1'b0;
            cy       <= 1'b0;
            zacc     <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            ccr_r    <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        op_r  <= OP;
                        len_r <= LEN;
                        a_r   <= A;
                        b_r   <= B;
                        xin_r <= XIN;
                        zin_r <= ZIN;
                        idx   <= '0;
                        cy    <= XIN & ((OP == OP_ADDX) || (OP == OP_SUBX));
                        zacc  <= 1'b1;
                        work  <= A;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    work <= work_nxt;
                    zacc <= z_nxt;
                    cy   <= ext[SLICE_W];
                    idx  <= idx + 1'b1;
                    if (last) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                        ccr_r  <= ccr_nxt;
                        if (op_r != OP_CMP)
                            result_r <= work_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY   = (state == S_RUN);
    assign DONE   = done_r;
    assign RESULT = result_r;
    assign CCR    = ccr_r;

endmodule
